array_mem: RTL and testbench
============================

Name: array_mem

Overview:
- Single-port on-chip word memory that serves as the backing store for an Array-typed port.
- Consumers such as stream-indexed array readers drive address/write requests into it and receive read data.
- After reset it self-initialises to an identity table (word i holds value i), then services one request per cycle with one-cycle read latency.

Parameters:
- INT_N, 8, data word width in bits.
- ADDR_N, 8, address width in bits; depth DEPTH = 2^ADDR_N words.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- out0_valid  in  1  client request valid.
- out0_ready  out  1  array accepts request this cycle.
- out0_addr  in  ADDR_N  request word address.
- out0_we  in  1  1 = write request, 0 = read request.
- out0_di  in  INT_N  write data.
- out0_do  out  INT_N  read/response data.

Behaviour:
- Reset (rst=1 at clk edge):
  - state <= INIT, init pointer <= 0, out0_do <= 0.
  - out0_ready is 0 while rst is high.
  - Memory contents are not cleared directly; the INIT sweep rewrites them.
- INIT state:
  - Each cycle writes mem[ptr] <= ptr, zero-extended to INT_N if INT_N > ADDR_N, truncated to the low INT_N bits if INT_N < ADDR_N. Then ptr <= ptr+1.
  - After writing ptr = DEPTH-1, state <= RUN. INIT therefore lasts exactly DEPTH cycles.
  - out0_ready = 0 throughout; client requests are ignored (not queued).
- RUN state:
  - out0_ready = 1, combinational from state (not from valid), so there is no valid-to-ready combinational path.
  - A request is accepted on any edge where out0_valid & out0_ready.
  - Accepted read: out0_do <= mem[out0_addr]; data is valid the cycle after acceptance (latency 1).
  - Accepted write: mem[out0_addr] <= out0_di and out0_do <= out0_di (write-through response, latency 1).
  - No accepted request: out0_do holds its last value.
- Back-to-back requests one per cycle are supported. Read-after-write to the same address on the next cycle returns the new data.
- The response has no backpressure; the client must capture out0_do in the cycle after acceptance.
- Address is always in range (full ADDR_N decode); there is no out-of-range case.
- Reset asserted mid-RUN or mid-INIT aborts any request and restarts the INIT sweep from ptr 0. The previous contents are overwritten by the sweep.
- out0_we is ignored unless out0_valid is high.

Decomposition:
- Shared package holds INT_N / ADDR_N defaults and the Array port field layout (addr, we, di, do, valid, ready) used by all Array producers and consumers.
- One sub-module is natural: array_spram, a parameterised single-port synchronous RAM with one write port and a registered read.
- array_mem wraps array_spram with the INIT/RUN FSM, the init pointer and the mux between init-write and client request.

Test Plan:
- Reset then idle: assert rst 2 cycles, release -> out0_ready=0 for exactly 256 cycles, then 1; out0_do=0.
- Identity readback: after init, read addresses 0..15 one per cycle -> out0_do = 0,1,...,15, each one cycle after acceptance; address 15 yields 15.
- Write then read: write addr 0x20 data 0xA5 -> out0_do=0xA5 next cycle; read 0x20 on the following cycle -> 0xA5; read 0x21 -> 0x21.
- Requests during INIT: hold out0_valid=1, we=1, addr=3, di=0xFF during the sweep -> ignored, ready=0; post-init read of 3 -> 3.
- Mid-operation reset: write 0x55 to addr 7, pulse rst -> 256-cycle reinit; read 7 -> 7.
- Hold behaviour: read addr 9, then deassert valid 5 cycles -> out0_do stays 9.

Source files
------------

// File: rtl/array_mem_pkg.sv
// Shared definitions for Array-typed ports: default widths, the request field
// layout used by every producer/consumer, and the backing-store FSM states.
package array_mem_pkg;

    localparam int INT_N_DEF  = 8;
    localparam int ADDR_N_DEF = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } array_state_e;

    // Request side of an Array port; the response is a bare out0_do word.
    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [ADDR_N_DEF-1:0] addr;
        logic [INT_N_DEF-1:0]  di;
    } array_req_t;

    typedef struct packed {
        logic                 ready;
        logic [INT_N_DEF-1:0] dout;
    } array_rsp_t;

endpackage

// File: rtl/array_mem_spram.sv
// Single-port synchronous RAM with a registered, write-first read port whose
// output register only updates when rd_en_i is high (so it holds otherwise).
module array_spram #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // A write returns its own data so back-to-back write/read sees fresh values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= we_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/array_mem.sv
// Array-port backing store: after reset sweeps an identity table into the RAM,
// then serves one read or write request per cycle with one-cycle latency.
module array_mem
    import array_mem_pkg::*;
#(
    parameter int INT_N  = INT_N_DEF,
    parameter int ADDR_N = ADDR_N_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out0_valid,
    output logic              out0_ready,
    input  logic [ADDR_N-1:0] out0_addr,
    input  logic              out0_we,
    input  logic [INT_N-1:0]  out0_di,
    output logic [INT_N-1:0]  out0_do
);

    array_state_e      state_q, state_d;
    logic [ADDR_N-1:0] ptr_q, ptr_d;
    logic [INT_N-1:0]  init_data;
    logic              init_wr;
    logic              accept;
    logic              ram_we;
    logic [ADDR_N-1:0] ram_addr;
    logic [INT_N-1:0]  ram_wdata;

    // Init pattern is the pointer zero-extended or truncated to the word width.
    for (genvar gi = 0; gi < INT_N; gi++) begin : g_init_data
        if (gi < ADDR_N) begin : g_bit
            assign init_data[gi] = ptr_q[gi];
        end else begin : g_zero
            assign init_data[gi] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == {ADDR_N{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ptr_d = ptr_q;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Ready depends only on state and reset, never on valid.
    assign out0_ready = (state_q == ST_RUN) && !rst;
    assign accept     = out0_valid && out0_ready;
    assign init_wr    = (state_q == ST_INIT) && !rst;

    assign ram_we    = init_wr || (accept && out0_we);
    assign ram_addr  = init_wr ? ptr_q : out0_addr;
    assign ram_wdata = init_wr ? init_data : out0_di;

    array_spram #(
        .DW (INT_N),
        .AW (ADDR_N)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .rd_en_i (accept),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (out0_do)
    );

endmodule

// File: tb/tb_array_mem.sv
// Directed and randomized checks of array_mem against a plain array model.
module tb_array_mem;

    localparam int INT_N  = 8;
    localparam int ADDR_N = 8;
    localparam int DEPTH  = 1 << ADDR_N;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              out0_valid = 1'b0;
    logic              out0_ready;
    logic [ADDR_N-1:0] out0_addr = '0;
    logic              out0_we = 1'b0;
    logic [INT_N-1:0]  out0_di = '0;
    logic [INT_N-1:0]  out0_do;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [INT_N-1:0] ref_mem [DEPTH];
    logic [INT_N-1:0] ref_do;

    always #5 clk = ~clk;

    array_mem #(.INT_N(INT_N), .ADDR_N(ADDR_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_addr  (out0_addr),
        .out0_we    (out0_we),
        .out0_di    (out0_di),
        .out0_do    (out0_do)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset, then count the not-ready cycles of the init sweep.
    task automatic reset_and_init(input int rst_cycles);
        int cnt;
        rst = 1'b1;
        repeat (rst_cycles) tick();
        rst = 1'b0;
        check("ready_low_after_reset", {31'b0, out0_ready}, 32'd0);
        cnt = 0;
        while (!out0_ready && cnt < 400) begin
            cnt++;
            tick();
        end
        check("init_cycles", cnt, DEPTH);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INT_N'(i);
        ref_do = '0;
        check("do_after_init", {24'b0, out0_do}, {24'b0, ref_do});
        $display("reset: rst %0d cycles, init took %0d cycles, do=0x%0h", rst_cycles, cnt, out0_do);
    endtask

    // One cycle of client activity; model applies it only if it is accepted.
    task automatic cycle(input logic v, input logic w, input logic [ADDR_N-1:0] a,
                         input logic [INT_N-1:0] d, input string tag);
        out0_valid = v;
        out0_we    = w;
        out0_addr  = a;
        out0_di    = d;
        #1;
        check({tag, "_ready"}, {31'b0, out0_ready}, 32'd1);
        tick();
        if (v) begin
            if (w) begin
                ref_mem[a] = d;
                ref_do     = d;
            end else begin
                ref_do = ref_mem[a];
            end
        end
        check({tag, "_do"}, {24'b0, out0_do}, {24'b0, ref_do});
        $display("%s: v=%0b we=%0b addr=0x%02h di=0x%02h -> do=0x%02h exp=0x%02h",
                 tag, v, w, a, d, out0_do, ref_do);
        out0_valid = 1'b0;
        out0_we    = 1'b0;
    endtask

    initial begin
        ref_do = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = INT_N'(i);

        // Reset then idle
        reset_and_init(2);

        // Identity readback, back-to-back
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, ADDR_N'(i), '0, "ident_rd");
        check("ident_addr15", {24'b0, out0_do}, 32'd15);

        // Write then read
        cycle(1'b1, 1'b1, 8'h20, 8'hA5, "wr20");
        check("wr20_through", {24'b0, out0_do}, 32'hA5);
        cycle(1'b1, 1'b0, 8'h20, 8'h00, "rd20");
        check("rd20_value", {24'b0, out0_do}, 32'hA5);
        cycle(1'b1, 1'b0, 8'h21, 8'h00, "rd21");
        check("rd21_value", {24'b0, out0_do}, 32'h21);

        // Requests held during reset and the whole sweep are ignored
        out0_valid = 1'b1;
        out0_we    = 1'b1;
        out0_addr  = 8'h03;
        out0_di    = 8'hFF;
        reset_and_init(2);
        out0_valid = 1'b0;
        out0_we    = 1'b0;
        cycle(1'b1, 1'b0, 8'h03, 8'h00, "rd3_post_init");
        check("rd3_identity", {24'b0, out0_do}, 32'h03);

        // Mid-operation reset rewrites previous contents
        cycle(1'b1, 1'b1, 8'h07, 8'h55, "wr7");
        reset_and_init(1);
        cycle(1'b1, 1'b0, 8'h07, 8'h00, "rd7_after_reset");
        check("rd7_identity", {24'b0, out0_do}, 32'h07);

        // Hold: no request keeps the last response
        cycle(1'b1, 1'b0, 8'h09, 8'h00, "rd9");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 8'h09, 8'h00, "hold9");
        check("hold9_value", {24'b0, out0_do}, 32'h09);

        // Valid low with we high must not write
        cycle(1'b0, 1'b1, 8'h40, 8'hEE, "we_no_valid");
        cycle(1'b1, 1'b0, 8'h40, 8'h00, "rd40");
        check("rd40_unwritten", {24'b0, out0_do}, 32'h40);

        // Randomized traffic, narrow address window to force RAW hits
        for (int i = 0; i < 300; i++) begin
            logic v, w;
            logic [ADDR_N-1:0] a;
            logic [INT_N-1:0] d;
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) != 0;
            a = (i < 150) ? ADDR_N'($urandom_range(0, 7)) : ADDR_N'($urandom);
            d = INT_N'($urandom);
            if (i == 200) reset_and_init(1);
            cycle(v, w, a, d, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
